dcache_nway: RTL

//  Parametrised N-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the AXI bridge.

---
 rtl/dcache_nway_if.sv | 48 ++++
 rtl/dcache_nway.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_nway_if.sv
// Bus bundle for dcache_nway: pipeline request/response side plus memory refill and write-through side.
// The hit/miss counter signals exist only when DCACHE_STATS_EN is defined.
interface dcache_nway_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              ce_ram_in;
  logic              r_ena_in;
  logic [ADDR_W-1:0] raddr_in;
  logic [ADDR_W-1:0] waddr_in;
  logic [DATA_W-1:0] wdata_in;
  logic [7:0]        sel_in;
  logic [DATA_W-1:0] rdata_out;
  logic              stall_cache;
  logic [ADDR_W-1:0] mem_raddr_out;
  logic              mem_r_ena_out;
  logic              axi_r_valid;
  logic [DATA_W-1:0] mem_rdata_in;
  logic [ADDR_W-1:0] mem_waddr_out;
  logic [DATA_W-1:0] mem_wdata_out;
  logic [7:0]        mem_sel_out;
  logic              mem_w_ena_out;
  logic              mem_w_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0]       hit_cnt_out;
  logic [31:0]       miss_cnt_out;
`endif

  modport slave (
    input  ce_ram_in, r_ena_in, raddr_in, waddr_in, wdata_in, sel_in,
    input  axi_r_valid, mem_rdata_in, mem_w_ready,
    output rdata_out, stall_cache, mem_raddr_out, mem_r_ena_out,
    output mem_waddr_out, mem_wdata_out, mem_sel_out, mem_w_ena_out
`ifdef DCACHE_STATS_EN
    , output hit_cnt_out, miss_cnt_out
`endif
  );

  modport master (
    output ce_ram_in, r_ena_in, raddr_in, waddr_in, wdata_in, sel_in,
    output axi_r_valid, mem_rdata_in, mem_w_ready,
    input  rdata_out, stall_cache, mem_raddr_out, mem_r_ena_out,
    input  mem_waddr_out, mem_wdata_out, mem_sel_out, mem_w_ena_out
`ifdef DCACHE_STATS_EN
    , input hit_cnt_out, miss_cnt_out
`endif
  );
endinterface

// File: rtl/dcache_nway.sv
// N-way set-associative write-through, no-write-allocate data cache with per-set round-robin victims.
// Optional DCACHE_STATS_EN adds saturating hit/miss counters on the interface.
module dcache_nway #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input logic          clk,
  input logic          rst,
  dcache_nway_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = ADDR_W - IDX_W - 3;

  typedef enum logic [2:0] {IDLE, REFILL, RESP, WRITE, RESP_W} state_t;
  state_t state_q, state_d;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]        sel_q, sel_d;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [WAYS-1:0]   way_hit;
  logic              hit, has_inv, refill_we, store_we;
  logic [WAY_W-1:0]  hit_way, inv_way, victim;

  // Idle lookups use the live load address; busy states reuse the latched request.
  assign lk_idx = (state_q == IDLE) ? bus.raddr_in[IDX_W+2:3] : addr_q[IDX_W+2:3];
  assign lk_tag = (state_q == IDLE) ? bus.raddr_in[ADDR_W-1:IDX_W+3] : addr_q[ADDR_W-1:IDX_W+3];

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign way_hit[gi] = valid_q[lk_idx][gi] && (tag_q[lk_idx][gi] == lk_tag);
    end
  endgenerate

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[lk_idx][w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    victim = has_inv ? inv_way : rr_q[lk_idx];
  end

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    sel_d             = sel_q;
    rdata_d           = rdata_q;
    refill_we         = 1'b0;
    store_we          = 1'b0;
    bus.rdata_out     = '0;
    bus.stall_cache   = 1'b0;
    bus.mem_raddr_out = '0;
    bus.mem_r_ena_out = 1'b0;
    bus.mem_waddr_out = '0;
    bus.mem_wdata_out = '0;
    bus.mem_sel_out   = '0;
    bus.mem_w_ena_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ce_ram_in) begin
          if (bus.r_ena_in) begin
            if (hit) begin
              bus.rdata_out = data_q[lk_idx][hit_way];
            end else begin
              bus.stall_cache = 1'b1;
              addr_d          = bus.raddr_in;
              state_d         = REFILL;
            end
          end else begin
            bus.stall_cache = 1'b1;
            addr_d          = bus.waddr_in;
            wdata_d         = bus.wdata_in;
            sel_d           = bus.sel_in;
            state_d         = WRITE;
          end
        end
      end
      REFILL: begin
        bus.stall_cache   = 1'b1;
        bus.mem_r_ena_out = 1'b1;
        bus.mem_raddr_out = {addr_q[ADDR_W-1:3], 3'b000};
        if (bus.axi_r_valid) begin
          refill_we = 1'b1;
          rdata_d   = bus.mem_rdata_in;
          state_d   = RESP;
        end
      end
      RESP: begin
        bus.rdata_out = rdata_q;
        state_d       = IDLE;
      end
      WRITE: begin
        bus.stall_cache   = 1'b1;
        bus.mem_w_ena_out = 1'b1;
        bus.mem_waddr_out = addr_q;
        bus.mem_wdata_out = wdata_q;
        bus.mem_sel_out   = sel_q;
        if (bus.mem_w_ready) begin
          store_we = hit;
          state_d  = RESP_W;
        end
      end
      RESP_W:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      if (refill_we) begin
        valid_q[lk_idx][victim] <= 1'b1;
        // Round-robin only advances when a valid line was actually displaced.
        if (!has_inv) begin
          rr_q[lk_idx] <= (rr_q[lk_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[lk_idx] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && refill_we) begin
      tag_q[lk_idx][victim]  <= lk_tag;
      data_q[lk_idx][victim] <= bus.mem_rdata_in;
    end
    if (rst && store_we) begin
      for (int b = 0; b < 8; b++) begin
        if (sel_q[b]) data_q[lk_idx][hit_way][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        load_hit, miss_start;

  assign load_hit   = (state_q == IDLE) && bus.ce_ram_in && bus.r_ena_in && hit;
  assign miss_start = (state_q == IDLE) && (state_d == REFILL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (load_hit && (hit_cnt_q != '1))    hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.hit_cnt_out  = hit_cnt_q;
  assign bus.miss_cnt_out = miss_cnt_q;
`endif
endmodule
